uart_cmd_rx: RTL and testbench

ASCII command receiver for the UART link: the return path to the board's ASCII telemetry transmitter. It deserialises 8N1 UART bytes and parses lines of the form "CHn:ddddd\n". The decimal value is converted to a 16-bit binary word and written into a per-channel register bank. Host software uses it to set per-channel thresholds and offsets in the same text format the board emits.

---
 rtl/uart_cmd_pkg.sv | 32 +++
 rtl/uart_rx.sv | 142 ++++++++++++++
 rtl/uart_cmd_rx.sv | 133 +++++++++++++
 tb/tb_uart_cmd_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared parser state type, ASCII constants and limits for the UART command receiver.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        P_IDLE,
        P_H,
        P_NUM,
        P_COLON,
        P_DIG,
        P_EOL
    } parse_state_e;

    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_H     = 8'h48;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;

    localparam int NUM_CH    = 8;
    localparam int DIGITS    = 5;
    localparam int VALUE_MAX = 65535;

    function automatic logic is_dec(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_0 + 8'd9);
    endfunction

    function automatic logic is_chan(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_0 + 8'(NUM_CH - 1));
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART byte receiver: 2-flop synchroniser, mid-bit sampling, 8N1 framing.
// Define UART_CMD_PARITY_EN for 8E1 (even parity bit after D7).
module uart_rx #(
    parameter int BIT_CYCLES = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_line,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    localparam int                CNT_W   = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_e;

    rx_state_e        state_q, state_d;
    logic [1:0]       sync_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rx_s;
    logic             perr;

    assign rx_s = sync_q[1];

`ifdef UART_CMD_PARITY_EN
    logic perr_q, perr_d;
    assign perr = perr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perr_q <= 1'b0;
        else        perr_q <= perr_d;
    end
`else
    assign perr = 1'b0;
`endif

    // Synchroniser flops reset high so the idle line never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= R_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_line};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_CMD_PARITY_EN
        perr_d  = perr_q;
`endif
        unique case (state_q)
            R_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_s) state_d = R_START;
            end
            R_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_CMD_PARITY_EN
                        state_d = R_PAR;
`else
                        state_d = R_STOP;
`endif
                    end
                end
            end
            R_PAR: begin
`ifdef UART_CMD_PARITY_EN
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    perr_d  = rx_s ^ (^shift_q);
                    state_d = R_STOP;
                end
`else
                state_d = R_IDLE;
`endif
            end
            R_STOP: begin
                // Returning to idle at the stop mid-sample lets a back-to-back start bit be caught.
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = R_IDLE;
                    if (rx_s && !perr) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    assign rx_valid = valid_q;
    assign rx_data  = data_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// ASCII command receiver: parses "CHn:ddddd\n" lines from uart_rx into a per-channel register bank.
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLK_FRE    = 50,
    parameter int UART_RATE  = 115200,
    parameter int BIT_CYCLES = CLK_FRE * 1000000 / UART_RATE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     uart_rx,
    output logic                     cmd_valid,
    output logic [2:0]               cmd_ch,
    output logic [15:0]              cmd_value,
    output logic                     cmd_err,
    output logic [NUM_CH-1:0][15:0]  ch_data
);

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ferr;

    uart_rx #(.BIT_CYCLES(BIT_CYCLES)) u_uart_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_line  (uart_rx),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ferr  (rx_ferr)
    );

    parse_state_e             state_q, state_d;
    logic [2:0]               ch_q, ch_d;
    logic [16:0]              acc_q, acc_d;
    logic [2:0]               dcnt_q, dcnt_d;
    logic                     commit, err;
    logic                     cmd_valid_q, cmd_err_q;
    logic [2:0]               cmd_ch_q;
    logic [15:0]              cmd_value_q;
    logic [NUM_CH-1:0][15:0]  ch_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the bank is eight flop words, not a RAM, so it is reset along with the rest.
        if (!rst_n) begin
            state_q     <= P_IDLE;
            ch_q        <= '0;
            acc_q       <= '0;
            dcnt_q      <= '0;
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_ch_q    <= '0;
            cmd_value_q <= '0;
            ch_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            acc_q       <= acc_d;
            dcnt_q      <= dcnt_d;
            cmd_valid_q <= commit;
            cmd_err_q   <= err;
            if (commit) begin
                cmd_ch_q        <= ch_q;
                cmd_value_q     <= acc_q[15:0];
                ch_data_q[ch_q] <= acc_q[15:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        acc_d   = acc_q;
        dcnt_d  = dcnt_q;
        commit  = 1'b0;
        err     = 1'b0;
        if (rx_ferr) begin
            if (state_q != P_IDLE) begin
                err     = 1'b1;
                state_d = P_IDLE;
            end
        end else if (rx_valid) begin
            unique case (state_q)
                P_IDLE:  if (rx_data == ASCII_C) state_d = P_H;
                P_H: begin
                    if (rx_data == ASCII_H) state_d = P_NUM;
                    else                    err     = 1'b1;
                end
                P_NUM: begin
                    if (is_chan(rx_data)) begin
                        ch_d    = rx_data[2:0];
                        acc_d   = '0;
                        dcnt_d  = '0;
                        state_d = P_COLON;
                    end else begin
                        err = 1'b1;
                    end
                end
                P_COLON: begin
                    if (rx_data == ASCII_COLON) state_d = P_DIG;
                    else                        err     = 1'b1;
                end
                P_DIG: begin
                    if (is_dec(rx_data)) begin
                        acc_d  = acc_q * 17'd10 + 17'(rx_data[3:0]);
                        dcnt_d = dcnt_q + 3'd1;
                        if (dcnt_q == 3'(DIGITS - 1)) state_d = P_EOL;
                    end else begin
                        err = 1'b1;
                    end
                end
                P_EOL: begin
                    if (rx_data == ASCII_LF) begin
                        if (acc_q > 17'(VALUE_MAX)) err    = 1'b1;
                        else                        commit = 1'b1;
                        state_d = P_IDLE;
                    end else if (rx_data != ASCII_CR) begin
                        err = 1'b1;
                    end
                end
                default: state_d = P_IDLE;
            endcase
            // A stray 'C' is treated as the start of a new line.
            if (err) state_d = (rx_data == ASCII_C) ? P_H : P_IDLE;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_err   = cmd_err_q;
    assign cmd_ch    = cmd_ch_q;
    assign cmd_value = cmd_value_q;
    assign ch_data   = ch_data_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx: directed line table, corner sequences and random lines.
module tb_uart_cmd_rx;

    localparam int CLK_FRE   = 1;
    localparam int UART_RATE = 125000;
    localparam int BC        = CLK_FRE * 1000000 / UART_RATE;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx_line = 1'b1;
    logic             cmd_valid;
    logic [2:0]       cmd_ch;
    logic [15:0]      cmd_value;
    logic             cmd_err;
    logic [7:0][15:0] ch_data;

    uart_cmd_rx #(.CLK_FRE(CLK_FRE), .UART_RATE(UART_RATE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (rx_line),
        .cmd_valid (cmd_valid),
        .cmd_ch    (cmd_ch),
        .cmd_value (cmd_value),
        .cmd_err   (cmd_err),
        .ch_data   (ch_data)
    );

    always #5 clk = ~clk;

    int valid_cnt = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int n_checks  = 0;
    int n_errors  = 0;

    logic [7:0][15:0] exp_bank = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid) valid_cnt++;
            if (cmd_err)   err_cnt++;
            if (cmd_valid && cmd_err) both_cnt++;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx_line = 1'b0;
        repeat (BC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (BC) @(negedge clk);
        end
`ifdef UART_CMD_PARITY_EN
        rx_line = ^b;
        repeat (BC) @(negedge clk);
`endif
        rx_line = !bad_stop;
        repeat (BC) @(negedge clk);
        if (bad_stop) begin
            rx_line = 1'b1;
            repeat (BC) @(negedge clk);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
    endtask

    function automatic string dec(input int v, input int nd);
        string r = "";
        int    p = 1;
        for (int k = 1; k < nd; k++) p *= 10;
        for (int k = 0; k < nd; k++) begin
            r = {r, $sformatf("%c", 48 + (v / p) % 10)};
            p /= 10;
        end
        return r;
    endfunction

    task automatic run_line(input string name, input string s, input int ev, input int ee,
                            input int ech, input int eval);
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_str(s);
        repeat (4) @(negedge clk);
        check({name, " valid pulses"}, 128'(valid_cnt - v0), 128'(ev));
        check({name, " err pulses"}, 128'(err_cnt - e0), 128'(ee));
        if (ev > 0) begin
            exp_bank[ech] = 16'(eval);
            check({name, " cmd_ch"}, 128'(cmd_ch), 128'(ech));
            check({name, " cmd_value"}, 128'(cmd_value), 128'(eval));
        end
        check({name, " ch_data"}, ch_data, exp_bank);
    endtask

    typedef struct {
        string name;
        string line;
        int    n_valid;
        int    n_err;
        int    ch;
        int    value;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int v0, e0;
        int kind, ch, val, ev, ee;
        string s;
        logic [7:0] pb;

        vecs[0] = '{"basic",     "CH3:01234\n",     1, 0, 3, 1234};
        vecs[1] = '{"max_cr",    "CH7:65535\r\n",   1, 0, 7, 65535};
        vecs[2] = '{"overflow",  "CH7:65536\n",     0, 1, 0, 0};
        vecs[3] = '{"resync",    "CHCH0:00042\n",   1, 1, 0, 42};
        vecs[4] = '{"short",     "CH5:1234\n",      0, 1, 0, 0};
        vecs[5] = '{"long",      "CH2:123456\n",    0, 1, 0, 0};
        vecs[6] = '{"zero",      "CH1:00000\n",     1, 0, 1, 0};
        vecs[7] = '{"ovf_max",   "zzCH6:99999\n",   0, 1, 0, 0};
        vecs[8] = '{"two_cr",    "CH4:00007\r\r\n", 1, 0, 4, 7};
        vecs[9] = '{"bad_colon", "CH4;00009\n",     0, 1, 0, 0};

        repeat (5) @(negedge clk);
        check("reset cmd_valid", 128'(cmd_valid), 128'(0));
        check("reset cmd_err", 128'(cmd_err), 128'(0));
        check("reset cmd_ch", 128'(cmd_ch), 128'(0));
        check("reset cmd_value", 128'(cmd_value), 128'(0));
        check("reset ch_data", ch_data, 128'(0));
        rst_n = 1'b1;
        repeat (BC) @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_line(vecs[i].name, vecs[i].line, vecs[i].n_valid, vecs[i].n_err,
                     vecs[i].ch, vecs[i].value);

        // Bad channel digit: the error must appear as soon as '8' is consumed.
        v0 = valid_cnt;
        e0 = err_cnt;
        send_str("CH8");
        repeat (4) @(negedge clk);
        check("ch8 err at digit", 128'(err_cnt - e0), 128'(1));
        send_str(":00001\n");
        repeat (4) @(negedge clk);
        check("ch8 err total", 128'(err_cnt - e0), 128'(1));
        check("ch8 no commit", 128'(valid_cnt - v0), 128'(0));
        check("ch8 bank", ch_data, exp_bank);

        // Framing error in the middle of the digits.
        v0 = valid_cnt;
        e0 = err_cnt;
        send_str("CH1:00");
        send_byte(8'h35, 1'b1);
        repeat (4) @(negedge clk);
        check("ferr err", 128'(err_cnt - e0), 128'(1));
        check("ferr no commit", 128'(valid_cnt - v0), 128'(0));
        run_line("ferr_after", "CH1:00005\n", 1, 0, 1, 5);

        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 3));
            ch   = int'($urandom_range(0, 7));
            val  = 0;
            ev   = 0;
            ee   = 1;
            case (kind)
                0: begin
                    val = int'($urandom_range(0, 99999));
                    s   = {"CH", dec(ch, 1), ":", dec(val, 5),
                           ($urandom_range(0, 1) != 0) ? "\r\n" : "\n"};
                    ev  = (val <= 65535) ? 1 : 0;
                    ee  = 1 - ev;
                end
                1: s = {"CH", dec(int'($urandom_range(8, 9)), 1), ":00001\n"};
                2: s = {"CH", dec(ch, 1), ":", dec(int'($urandom_range(0, 9999)), 4), "\n"};
                default: begin
                    val = int'($urandom_range(0, 65535));
                    s   = {"xy", "CH", dec(ch, 1), ":", dec(val, 5), "\n"};
                    ev  = 1;
                    ee  = 0;
                end
            endcase
            run_line($sformatf("rnd%0d", i), s, ev, ee, ch, val);
        end

        // Reset during digit 3 of "CH2:11111\n".
        send_str("CH2:11");
        pb = 8'h31;
        rx_line = 1'b0;
        repeat (BC) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_line = pb[i];
            repeat (BC) @(negedge clk);
        end
        v0 = valid_cnt;
        e0 = err_cnt;
        rx_line = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst ctrl", 128'({cmd_valid, cmd_err, cmd_ch, cmd_value}), 128'(0));
        check("midrst ch_data", ch_data, 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_bank = '0;
        repeat (2 * BC) @(negedge clk);
        check("midrst no pulse", 128'((valid_cnt - v0) + (err_cnt - e0)), 128'(0));
        run_line("midrst_tail", "11\n", 0, 0, 0, 0);
        run_line("midrst_fresh", "CH2:00321\n", 1, 0, 2, 321);

        check("valid_err overlap", 128'(both_cnt), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
